// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a small byte FIFO.
//
// Samples the synchronized line at mid-bit, checks the start and stop bits,
// and pushes good bytes into a FIFO_DEPTH-entry FIFO that the host drains
// with READ.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each sample is the 2-of-3 majority of rx_s at terminal-2,
//               terminal-1 and terminal count.
//   undefined : each sample is rx_s at the terminal count.
//
// Parameters
//   PERIOD       clocks per bit
//   HALF_PERIOD  clocks from the detected start edge to the start-bit sample
//   FIFO_DEPTH   FIFO entries (power of two, >= 2)
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   RX         in   serial line, idles high, asynchronous to CLK
//   DATA       out  byte at the FIFO head (valid while VALID = 1)
//   VALID      out  FIFO not empty
//   READ       in   pop strobe, ignored while VALID = 0
//   FRAME_ERR  out  one-cycle pulse: stop bit sampled low
//   OVERRUN    out  one-cycle pulse: byte dropped, FIFO full
module uart_rx #(
    parameter int PERIOD      = 868,
    parameter int HALF_PERIOD = 434,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic       READ,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [9:0] T_HALF = 10'(HALF_PERIOD - 1);
    localparam logic [9:0] T_BIT  = 10'(PERIOD - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t       r_state;
    logic         r_rx_meta;
    logic         r_rx_s;
    logic         r_rx_prev;      // rx_s one cycle ago
`ifdef UART_RX_MAJORITY_EN
    logic         r_rx_prev2;     // rx_s two cycles ago
`endif
    logic [9:0]   r_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic         r_frame_err;
    logic         r_overrun;
    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]  r_count;

    logic w_sample;
    logic w_term;
    logic w_push;
    logic w_pop;
    logic w_full;

    // Two-flop synchronizer plus history for edge detect / majority vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            r_rx_prev2 <= 1'b1;
`endif
        end else begin
            r_rx_meta  <= RX;
            r_rx_s     <= r_rx_meta;
            r_rx_prev  <= r_rx_s;
`ifdef UART_RX_MAJORITY_EN
            r_rx_prev2 <= r_rx_prev;
`endif
        end
    end

`ifdef UART_RX_MAJORITY_EN
    assign w_sample = (r_rx_s & r_rx_prev) | (r_rx_s & r_rx_prev2) | (r_rx_prev & r_rx_prev2);
`else
    assign w_sample = r_rx_s;
`endif

    // Terminal count of the bit timer for the current state.
    always_comb begin
        w_term = 1'b0;
        case (r_state)
            S_START:        w_term = (r_cnt == T_HALF);
            S_DATA, S_STOP: w_term = (r_cnt == T_BIT);
            default:        w_term = 1'b0;
        endcase
    end

    assign w_push = (r_state == S_STOP) && w_term && w_sample;
    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop  = READ && (r_count != '0);

    // Receive FSM and bit timer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_cnt       <= r_cnt + 10'd1;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (w_term) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_sample ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_term) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_sample, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_term) begin
                        r_cnt <= '0;
                        if (w_sample) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a held-low
                    // break cannot look like a new start bit.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO. A push into a full FIFO only lands if a pop frees a slot in the
    // same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= r_shift;
                    r_wr_ptr        <= r_wr_ptr + AW'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign DATA      = r_mem[r_rd_ptr];
    assign VALID     = (r_count != '0);
    assign FRAME_ERR = r_frame_err;
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Bit timing is shortened (PERIOD/HALF_PERIOD
// overridden) so the full sequence stays short; all timing below is written
// in terms of P and H. RX is changed 1 ns after a rising edge, so the
// synchronized edge is seen two clocks later and a sample for bit slot n
// (0 = start, 9 = stop) falls in the cycle after edge H+2+n*P.
module tb_uart_rx;
    localparam int P = 64;
    localparam int H = 32;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX = 1'b1;
    logic       READ = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_base;
    int ov_base;

    always #5 CLK = ~CLK;

    uart_rx #(.PERIOD(P), .HALF_PERIOD(H), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .RX(RX), .READ(READ),
        .DATA(DATA), .VALID(VALID), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    // Pulse counters for the flag outputs.
    always @(negedge CLK) begin
        if (FRAME_ERR === 1'b1) fe_cnt++;
        if (OVERRUN === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives a frame up to and including the stop-bit sample cycle; returns
    // inside that cycle. glitch2 puts a one-cycle high pulse on rx_s exactly
    // at the bit-2 sample point.
    task automatic frame_head(input logic [7:0] d, input logic stop, input logic glitch2);
        RX = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            if (i == 2 && glitch2) begin
                tick(H);
                RX = 1'b1;
                tick(1);
                RX = d[i];
                tick(P - H - 1);
            end else begin
                tick(P);
            end
        end
        RX = stop;
        tick(H + 2);
    endtask

    task automatic send_byte(input logic [7:0] d);
        frame_head(d, 1'b1, 1'b0);
        tick(P - H - 2);
    endtask

    logic [7:0] exp_q [4];

    initial begin
        // Reset values
        #23;
        chk("rst_data", DATA, 8'h00);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_fe", FRAME_ERR, 1'b0);
        chk("rst_ov", OVERRUN, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b1;
        tick(5);

        // 0xA5, no READ
        frame_head(8'hA5, 1'b1, 1'b0);
        chk("a5_valid_pre", VALID, 1'b0);
        tick(1);
        chk("a5_valid", VALID, 1'b1);
        chk("a5_data", DATA, 8'hA5);
        chk("a5_fe", FRAME_ERR, 1'b0);
        tick(P - H - 3);
        READ = 1'b1; tick(1); READ = 1'b0;
        chk("a5_pop_valid", VALID, 1'b0);

        // False start: low for less than the start sample delay
        fe_base = fe_cnt;
        RX = 1'b0; tick(H / 2);
        RX = 1'b1; tick(2 * P);
        chk("fs_valid", VALID, 1'b0);
        chk("fs_fe", fe_cnt, fe_base);
        send_byte(8'h3C);
        chk("3c_valid", VALID, 1'b1);
        chk("3c_data", DATA, 8'h3C);
        READ = 1'b1; tick(1); READ = 1'b0;

        // 0x55 with stop bit low, line held low as a break
        fe_base = fe_cnt;
        frame_head(8'h55, 1'b0, 1'b0);
        tick(1);
        chk("fe_pulse", FRAME_ERR, 1'b1);
        chk("fe_valid", VALID, 1'b0);
        tick(1);
        chk("fe_one_cycle", FRAME_ERR, 1'b0);
        tick(2000);
        chk("fe_hold_valid", VALID, 1'b0);
        RX = 1'b1; tick(P);
        chk("fe_count", fe_cnt, fe_base + 1);
        chk("fe_after_valid", VALID, 1'b0);

        // Overrun: five bytes, no READ
        ov_base = ov_cnt;
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        chk("full_head", DATA, 8'h01);
        frame_head(8'h05, 1'b1, 1'b0);
        tick(1);
        chk("ov_pulse", OVERRUN, 1'b1);
        tick(1);
        chk("ov_one_cycle", OVERRUN, 1'b0);
        tick(P - H - 4);
        chk("ov_count", ov_cnt, ov_base + 1);
        for (int k = 1; k <= 4; k++) begin
            chk("ov_valid", VALID, 1'b1);
            chk("ov_data", DATA, 8'(k));
            READ = 1'b1; tick(1); READ = 1'b0;
        end
        chk("ov_drained", VALID, 1'b0);

        // Full FIFO, READ coincident with the fifth push
        ov_base = ov_cnt;
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        frame_head(8'h05, 1'b1, 1'b0);
        READ = 1'b1; tick(1); READ = 1'b0;
        chk("pr_ov", OVERRUN, 1'b0);
        chk("pr_head", DATA, 8'h02);
        tick(P - H - 3);
        chk("pr_ov_count", ov_cnt, ov_base);
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
        READ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pr_drain", DATA, exp_q[k]);
            tick(1);
        end
        READ = 1'b0;
        chk("pr_empty", VALID, 1'b0);

        // Reset mid-bit-3 with a byte waiting in the FIFO
        send_byte(8'h99);
        chk("pre_rst_valid", VALID, 1'b1);
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        RX = 1'b0; tick(P);
        RX = 1'b1; tick(P);
        RX = 1'b0; tick(P);
        RX = 1'b1; tick(P);
        RX = 1'b0; tick(P / 2);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_valid", VALID, 1'b0);
        chk("mid_rst_data", DATA, 8'h00);
        chk("mid_rst_fe", FRAME_ERR, 1'b0);
        chk("mid_rst_ov", OVERRUN, 1'b0);
        RX = 1'b1;
        tick(3);
        RST = 1'b1;
        tick(P);
        send_byte(8'hC3);
        chk("c3_valid", VALID, 1'b1);
        chk("c3_data", DATA, 8'hC3);
        chk("rst_no_flags", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);
        READ = 1'b1; tick(1); READ = 1'b0;

        // One-cycle glitch on the bit-2 sample point of 0x00
        frame_head(8'h00, 1'b1, 1'b1);
        tick(1);
        chk("gl_valid", VALID, 1'b1);
`ifdef UART_RX_MAJORITY_EN
        chk("gl_data", DATA, 8'h00);
`else
        chk("gl_data", DATA, 8'h04);
`endif
        tick(P - H - 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
